// File: rtl/periph_timer_gpio_pkg.sv
// Shared constants and address decode for the timer/GPIO peripheral.
package periph_timer_gpio_pkg;

    // Default base of the register window
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    // Register byte offsets inside the 32-byte window
    localparam logic [4:0] OFF_TH   = 5'h00;
    localparam logic [4:0] OFF_TL   = 5'h04;
    localparam logic [4:0] OFF_TCON = 5'h08;
    localparam logic [4:0] OFF_LED  = 5'h0C;
    localparam logic [4:0] OFF_SW   = 5'h10;
    localparam logic [4:0] OFF_DIGI = 5'h14;
    localparam logic [4:0] OFF_CYC  = 5'h18;

    // TCON bit positions
    localparam int unsigned TCON_EN = 0;
    localparam int unsigned TCON_IE = 1;
    localparam int unsigned TCON_IS = 2;

    // Decoded register select
    typedef enum logic [2:0] {
        SelNone,
        SelTh,
        SelTl,
        SelTcon,
        SelLed,
        SelSw,
        SelDigi,
        SelCyc
    } reg_sel_e;

    // Map a byte address to a register; misaligned or out-of-window addresses select nothing
    function automatic reg_sel_e decode_addr(input logic [31:0] addr, input logic [31:0] base);
        reg_sel_e sel;
        sel = SelNone;
        if ((addr[31:5] == base[31:5]) && (addr[1:0] == 2'b00)) begin
            case (addr[4:0])
                OFF_TH:   sel = SelTh;
                OFF_TL:   sel = SelTl;
                OFF_TCON: sel = SelTcon;
                OFF_LED:  sel = SelLed;
                OFF_SW:   sel = SelSw;
                OFF_DIGI: sel = SelDigi;
                OFF_CYC:  sel = SelCyc;
                default:  sel = SelNone;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/periph_timer_gpio_sync_ff.sv
// Multi-stage flop synchronizer for asynchronous inputs; output is the last stage.
module periph_timer_gpio_sync_ff #(
    parameter int unsigned Width  = 8,
    parameter int unsigned Stages = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] stage_q [Stages];

    // Shift the raw input through the flop chain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Stages; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < Stages; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[Stages-1];

endmodule

// File: rtl/periph_timer_gpio.sv
// Memory-mapped reload timer with interrupt, LED/switch/7-segment registers and a
// free-running cycle counter, sitting on the MEM-stage data bus.
module periph_timer_gpio
    import periph_timer_gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter int unsigned SW_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irqout,
    input  logic [7:0]  switch,
    output logic [7:0]  led,
    output logic [11:0] digi
);

    reg_sel_e    sel;
    logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digi, wr_cyc;
    logic        tl_max;
    logic [31:0] th_q, tl_q, tl_d, cyc_q, cyc_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, sw_sync;
    logic [11:0] digi_q;

    assign sel     = decode_addr(addr, BASE_ADDR);
    assign wr_th   = wr && (sel == SelTh);
    assign wr_tl   = wr && (sel == SelTl);
    assign wr_tcon = wr && (sel == SelTcon);
    assign wr_led  = wr && (sel == SelLed);
    assign wr_digi = wr && (sel == SelDigi);
    assign wr_cyc  = wr && (sel == SelCyc);
    assign tl_max  = (tl_q == 32'hFFFF_FFFF);

    periph_timer_gpio_sync_ff #(
        .Width  (8),
        .Stages (SW_SYNC_STAGES)
    ) u_sw_sync (
        .clk    (clk),
        .reset  (reset),
        .data_i (switch),
        .data_o (sw_sync)
    );

    // Timer next state: CPU writes take priority over counting and reload
    always_comb begin
        tl_d   = tl_q;
        tcon_d = tcon_q;
        if (wr_tl) begin
            tl_d = wdata;
        end else if (tcon_q[TCON_EN]) begin
            tl_d = tl_max ? th_q : tl_q + 32'd1;
        end
        if (wr_tcon) begin
            tcon_d = wdata[2:0];
        end else if (tcon_q[TCON_EN] && tl_max && tcon_q[TCON_IE]) begin
            tcon_d[TCON_IS] = 1'b1;
        end
    end

    // Cycle counter wraps naturally; a write clears it instead of incrementing
    always_comb begin
        cyc_d = wr_cyc ? 32'd0 : cyc_q + 32'd1;
    end

    // Register state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            led_q  <= '0;
            digi_q <= '0;
            cyc_q  <= '0;
        end else begin
            if (wr_th) begin
                th_q <= wdata;
            end
            if (wr_led) begin
                led_q <= wdata[7:0];
            end
            if (wr_digi) begin
                digi_q <= wdata[11:0];
            end
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            cyc_q  <= cyc_d;
        end
    end

    // Zero-latency read mux; returns pre-write values when rd and wr coincide
    always_comb begin
        rdata = '0;
        if (rd) begin
            case (sel)
                SelTh:   rdata = th_q;
                SelTl:   rdata = tl_q;
                SelTcon: rdata = {29'd0, tcon_q};
                SelLed:  rdata = {24'd0, led_q};
                SelSw:   rdata = {24'd0, sw_sync};
                SelDigi: rdata = {20'd0, digi_q};
                SelCyc:  rdata = cyc_q;
                default: rdata = '0;
            endcase
        end
    end

    assign irqout = tcon_q[TCON_IE] & tcon_q[TCON_IS];
    assign led    = led_q;
    assign digi   = digi_q;

endmodule

// File: tb/tb_periph_timer_gpio.sv
// Self-checking bench for periph_timer_gpio.
module tb_periph_timer_gpio;
    import periph_timer_gpio_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        irqout;
    logic [7:0]  switch, led;
    logic [11:0] digi;

    always #5 clk = ~clk;

    periph_timer_gpio #(
        .BASE_ADDR      (BASE),
        .SW_SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .irqout (irqout),
        .switch (switch),
        .led    (led),
        .digi   (digi)
    );

    typedef struct {
        string       name;
        logic [31:0] exp_rdata;
        logic        chk_irq;
        logic        exp_irq;
    } sb_t;

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_led;
        logic [11:0] exp_digi;
        string       name;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[19];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expectation and compare against the DUT outputs now
    task automatic compare_out();
        sb_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb_q.pop_front();
            check(e.name, rdata, e.exp_rdata);
            if (e.chk_irq) check({e.name, " irq"}, {31'd0, irqout}, {31'd0, e.exp_irq});
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; rd = 1'b0; addr = a; wdata = d;
        next_cycle();
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name,
                            input logic chk_irq = 1'b0, input logic exp_irq = 1'b0);
        rd = 1'b1; wr = 1'b0; addr = a;
        sb_q.push_back('{name, exp, chk_irq, exp_irq});
        @(negedge clk);
        compare_out();
        next_cycle();
        rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; switch = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        next_cycle();

        // Reset state
        check("rst led", {24'd0, led}, 32'd0);
        check("rst digi", {20'd0, digi}, 32'd0);
        check("rst irq", {31'd0, irqout}, 32'd0);
        bus_read(BASE + 32'h00, 32'd0, "rst TH");
        bus_read(BASE + 32'h04, 32'd0, "rst TL");
        bus_read(BASE + 32'h08, 32'd0, "rst TCON");
        bus_read(BASE + 32'h0C, 32'd0, "rst LED");
        bus_read(BASE + 32'h10, 32'd0, "rst SW");
        bus_read(BASE + 32'h14, 32'd0, "rst DIGI");

        // GPIO and decode table; led/digi expectations are the values before each edge
        vecs[0]  = '{1, 0, BASE + 32'h0C, 32'h0000_00A5, 32'h0, 8'h00, 12'h000, "wr LED"};
        vecs[1]  = '{0, 1, BASE + 32'h0C, 32'h0,         32'hA5, 8'hA5, 12'h000, "rd LED"};
        vecs[2]  = '{1, 0, BASE + 32'h14, 32'h00FF_F3C0, 32'h0, 8'hA5, 12'h000, "wr DIGI"};
        vecs[3]  = '{0, 1, BASE + 32'h14, 32'h0,         32'h3C0, 8'hA5, 12'h3C0, "rd DIGI"};
        vecs[4]  = '{1, 0, BASE + 32'h10, 32'h0000_00FF, 32'h0, 8'hA5, 12'h3C0, "wr SW"};
        vecs[5]  = '{0, 1, BASE + 32'h10, 32'h0,         32'h0, 8'hA5, 12'h3C0, "rd SW"};
        vecs[6]  = '{1, 0, BASE + 32'h1C, 32'hFFFF_FFFF, 32'h0, 8'hA5, 12'h3C0, "wr 1C"};
        vecs[7]  = '{1, 0, BASE + 32'h02, 32'h1234_5678, 32'h0, 8'hA5, 12'h3C0, "wr unal"};
        vecs[8]  = '{1, 0, BASE + 32'h20, 32'h0000_0077, 32'h0, 8'hA5, 12'h3C0, "wr outwin"};
        vecs[9]  = '{0, 1, BASE + 32'h1C, 32'h0,         32'h0, 8'hA5, 12'h3C0, "rd 1C"};
        vecs[10] = '{0, 1, BASE + 32'h02, 32'h0,         32'h0, 8'hA5, 12'h3C0, "rd unal"};
        vecs[11] = '{0, 1, BASE + 32'h00, 32'h0,         32'h0, 8'hA5, 12'h3C0, "rd TH"};
        vecs[12] = '{0, 1, BASE + 32'h04, 32'h0,         32'h0, 8'hA5, 12'h3C0, "rd TL"};
        vecs[13] = '{1, 1, BASE + 32'h0C, 32'h0000_003C, 32'hA5, 8'hA5, 12'h3C0, "rdwr LED"};
        vecs[14] = '{0, 1, BASE + 32'h0C, 32'h0,         32'h3C, 8'h3C, 12'h3C0, "rd LED2"};
        vecs[15] = '{0, 1, 32'h5000_0000, 32'h0,         32'h0, 8'h3C, 12'h3C0, "rd outwin"};
        vecs[16] = '{0, 1, BASE + 32'h08, 32'h0,         32'h0, 8'h3C, 12'h3C0, "rd TCON"};
        vecs[17] = '{1, 0, BASE + 32'h0D, 32'h0000_00FF, 32'h0, 8'h3C, 12'h3C0, "wr LED unal"};
        vecs[18] = '{0, 1, BASE + 32'h0C, 32'h0,         32'h3C, 8'h3C, 12'h3C0, "rd LED3"};

        foreach (vecs[i]) begin
            wr = vecs[i].w; rd = vecs[i].r; addr = vecs[i].a; wdata = vecs[i].d;
            sb_q.push_back('{vecs[i].name, vecs[i].exp_rdata, 1'b0, 1'b0});
            @(negedge clk);
            compare_out();
            check({vecs[i].name, " led"}, {24'd0, led}, {24'd0, vecs[i].exp_led});
            check({vecs[i].name, " digi"}, {20'd0, digi}, {20'd0, vecs[i].exp_digi});
            next_cycle();
            wr = 1'b0; rd = 1'b0;
        end

        // Switch synchronizer latency
        switch = 8'h5A;
        bus_read(BASE + 32'h10, 32'h0, "sw lat0");
        bus_read(BASE + 32'h10, 32'h0, "sw lat1");
        bus_read(BASE + 32'h10, 32'h5A, "sw lat2");

        // Cycle counter: clear then count
        bus_write(BASE + 32'h18, 32'h1234);
        bus_read(BASE + 32'h18, 32'd0, "cyc clr");
        bus_read(BASE + 32'h18, 32'd1, "cyc +1");
        repeat (3) next_cycle();
        bus_read(BASE + 32'h18, 32'd5, "cyc +5");

        // Reload with interrupt
        bus_write(BASE + 32'h00, 32'hFFFF_FFFC);
        bus_write(BASE + 32'h04, 32'hFFFF_FFFE);
        bus_write(BASE + 32'h08, 32'd3);
        bus_read(BASE + 32'h04, 32'hFFFF_FFFE, "irq TL0", 1'b1, 1'b0);
        bus_read(BASE + 32'h04, 32'hFFFF_FFFF, "irq TL1", 1'b1, 1'b0);
        bus_read(BASE + 32'h04, 32'hFFFF_FFFC, "irq reload", 1'b1, 1'b1);
        bus_read(BASE + 32'h08, 32'd7, "irq TCON", 1'b1, 1'b1);
        bus_write(BASE + 32'h08, 32'd3);
        bus_read(BASE + 32'h08, 32'd3, "irq clear", 1'b1, 1'b0);
        bus_write(BASE + 32'h08, 32'd0);

        // Overflow with interrupt disabled
        bus_write(BASE + 32'h00, 32'h100);
        bus_write(BASE + 32'h04, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h08, 32'd1);
        bus_read(BASE + 32'h04, 32'hFFFF_FFFF, "noie TL");
        bus_read(BASE + 32'h04, 32'h100, "noie reload", 1'b1, 1'b0);
        bus_read(BASE + 32'h08, 32'd1, "noie TCON", 1'b1, 1'b0);
        bus_write(BASE + 32'h08, 32'd0);

        // TL write in the overflow cycle wins
        bus_write(BASE + 32'h04, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h08, 32'd1);
        bus_write(BASE + 32'h04, 32'd5);
        bus_read(BASE + 32'h04, 32'd5, "tlcol 5");
        bus_read(BASE + 32'h04, 32'd6, "tlcol 6");
        bus_write(BASE + 32'h08, 32'd0);

        // TH write in the overflow cycle: reload uses old TH
        bus_write(BASE + 32'h04, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h08, 32'd1);
        bus_write(BASE + 32'h00, 32'h200);
        bus_read(BASE + 32'h04, 32'h100, "thcol TL");
        bus_read(BASE + 32'h00, 32'h200, "thcol TH");
        bus_write(BASE + 32'h08, 32'd0);

        // TCON write in the overflow cycle wins, status not set
        bus_write(BASE + 32'h04, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h08, 32'd3);
        bus_write(BASE + 32'h08, 32'd2);
        bus_read(BASE + 32'h08, 32'd2, "tconcol", 1'b1, 1'b0);
        bus_read(BASE + 32'h04, 32'h200, "tconcol TL");

        // Asynchronous reset while counting with irq pending
        bus_write(BASE + 32'h00, 32'h1234);
        bus_write(BASE + 32'h04, 32'hFFFF_FFFE);
        bus_write(BASE + 32'h08, 32'd3);
        next_cycle();
        next_cycle();
        bus_read(BASE + 32'h04, 32'h1234, "pre-rst TL", 1'b1, 1'b1);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("arst irq", {31'd0, irqout}, 32'd0);
        check("arst led", {24'd0, led}, 32'd0);
        check("arst digi", {20'd0, digi}, 32'd0);
        rd = 1'b1; addr = BASE + 32'h04;
        #1;
        check("arst TL", rdata, 32'd0);
        rd = 1'b0;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        bus_read(BASE + 32'h04, 32'd0, "post-rst TL", 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
